// File: rtl/pulse_train_generator.sv
// rtl/pulse_train_generator.sv - programmable burst of registered pulses with start/busy/done framing
// Each pulse is HIGH_CYCLES high followed by LOW_CYCLES low; the trailing low phase is always emitted.
module pulse_train_generator #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter int TIMER_W     = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic             cancel,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] HIGH_LAST = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOW_LAST  = TIMER_W'(LOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   remaining_nxt;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic               done_nxt;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    timer_nxt     = timer;
    done_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        // cancel in the same cycle as start drops the request entirely
        if (start && !cancel) begin
          if (num_pulses != '0) begin
            state_nxt     = S_HIGH;
            remaining_nxt = num_pulses;
            timer_nxt     = '0;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end

      S_HIGH: begin
        if (cancel) begin
          state_nxt     = S_IDLE;
          remaining_nxt = '0;
          timer_nxt     = '0;
        end else if (timer == HIGH_LAST) begin
          state_nxt = S_LOW;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end

      S_LOW: begin
        if (cancel) begin
          state_nxt     = S_IDLE;
          remaining_nxt = '0;
          timer_nxt     = '0;
        end else if (timer == LOW_LAST) begin
          timer_nxt = '0;
          if (remaining > CNT_ONE) begin
            state_nxt     = S_HIGH;
            remaining_nxt = remaining - CNT_ONE;
          end else begin
            state_nxt     = S_IDLE;
            remaining_nxt = '0;
            done_nxt      = 1'b1;
          end
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        remaining_nxt = '0;
        timer_nxt     = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      timer     <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      timer     <= timer_nxt;
      pulse_out <= (state_nxt == S_HIGH);
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb/tb_pulse_train_generator.sv - scoreboard bench for pulse_train_generator (H=2, L=3)
// Stimulus pushes the expected pulse_out/busy/done per cycle; the monitor pops and compares on negedge.
module tb_pulse_train_generator;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] num_pulses;
  logic       cancel;
  logic       pulse_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [2:0] v;
    int         tid;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  pulse_train_generator #(
    .HIGH_CYCLES(2),
    .LOW_CYCLES (3),
    .CNT_W      (8),
    .TIMER_W    (26)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_pulses(num_pulses),
    .cancel    (cancel),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({pulse_out, busy, done} !== e.v) begin
        miscompares++;
        $display("FAIL test%0d cycle %0d pulse/busy/done: got %b required %b",
                 e.tid, e.cyc, {pulse_out, busy, done}, e.v);
      end
    end
  end

  // Drive one cycle of inputs (sampled at the next edge) and queue the outputs expected after it.
  task automatic cyc(input logic s, input logic [7:0] n, input logic c,
                     input logic [2:0] ev, input int tid, input int k);
    start      = s;
    num_pulses = n;
    cancel     = c;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_t'{ev, tid, k});
  endtask

  task automatic run(input int tid, input int len,
                     input int st0, input int n0, input int st1, input int n1, input int cn,
                     input int pr[10], input int br[4], input int dn0, input int dn1);
    for (int c = 0; c < len; c++) begin
      logic       s;
      logic [7:0] n;
      logic [2:0] ev;
      int         k;
      k = c + 1;
      s = (c == st0) || (c == st1);
      n = (c == st0) ? 8'(n0) : (c == st1) ? 8'(n1) : 8'd7;
      ev[2] = 1'b0;
      for (int i = 0; i < 5; i++)
        if (k >= pr[2*i] && k <= pr[2*i+1]) ev[2] = 1'b1;
      ev[1] = (k >= br[0] && k <= br[1]) || (k >= br[2] && k <= br[3]);
      ev[0] = (k == dn0) || (k == dn1);
      cyc(s, n, (c == cn), ev, tid, k);
    end
    start  = 1'b0;
    cancel = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    cancel     = 1'b0;
    num_pulses = 8'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
      exp_q.push_back(exp_t'{3'b000, 0, 0});
    end
    reset = 1'b0;

    // 3 pulses: high 1-2, 6-7, 11-12; busy 1-15; done 16
    run(1, 18, 0, 3, -1, 0, -1, '{1, 2, 6, 7, 11, 12, 0, -1, 0, -1}, '{1, 15, 0, -1}, 16, -1);
    // zero-count request: done in cycle 1 only
    run(2, 4, 0, 0, -1, 0, -1, '{0, -1, 0, -1, 0, -1, 0, -1, 0, -1}, '{0, -1, 0, -1}, 1, -1);
    // start with 5 at cycle 4 while busy is ignored
    run(3, 18, 0, 3, 4, 5, -1, '{1, 2, 6, 7, 11, 12, 0, -1, 0, -1}, '{1, 15, 0, -1}, 16, -1);
    // cancel at cycle 6 inside pulse 2, fresh burst started at cycle 8
    run(4, 26, 0, 3, 8, 3, 6, '{1, 2, 6, 6, 9, 10, 14, 15, 19, 20}, '{1, 6, 9, 23}, 24, -1);
    // cancel together with start in IDLE: nothing happens
    run(7, 4, 0, 2, -1, 0, 0, '{0, -1, 0, -1, 0, -1, 0, -1, 0, -1}, '{0, -1, 0, -1}, -1, -1);

    // asynchronous reset mid-HIGH must clear outputs before the next edge
    cyc(1'b1, 8'd2, 1'b0, 3'b110, 5, 1);
    start = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_t'{3'b000, 5, 2});
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_t'{3'b000, 5, 3});
    reset = 1'b0;
    run(5, 8, 0, 1, -1, 0, -1, '{1, 2, 0, -1, 0, -1, 0, -1, 0, -1}, '{1, 5, 0, -1}, 6, -1);

    // back-to-back: second start sampled in the done cycle 16
    run(6, 24, 0, 3, 16, 1, -1, '{1, 2, 6, 7, 11, 12, 17, 18, 0, -1}, '{1, 15, 17, 21}, 16, 22);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Generates a programmable burst of clean, registered pulses on a single output line. It is the transmit-side counterpart to the team's edge-detect/pulse-stretch input logic: it produces the rising edges that such detectors consume, for LED/strobe stimulus and inter-block signalling. A start/busy/done handshake frames each burst.

## Interface
- HIGH_CYCLES, default 4: clock cycles `pulse_out` stays high per pulse. Must be ≥1 and <2^TIMER_W.
- LOW_CYCLES, default 4: clock cycles `pulse_out` stays low after each pulse, including after the last one. Must be ≥1 and <2^TIMER_W.
- CNT_W, default 8: width of the pulse-count request.
- TIMER_W, default 26: width of the internal phase timer.
- clk  input  1  system clock. All logic is rising-edge.
- reset  input  1  asynchronous, active-high. Clears all state and outputs.
- start  input  1  burst request, sampled on a rising clk edge. Accepted only when `busy`=0.
- num_pulses  input  CNT_W  pulse count for the burst, latched when `start` is accepted.
- cancel  input  1  aborts the current burst.
- pulse_out  output  1  generated pulse train, registered.
- busy  output  1  high while a burst is in progress, registered.
- done  output  1  one-cycle completion strobe, registered.

## Operation
- States: IDLE, HIGH, LOW.
- Internal registers:
  - remaining (CNT_W): pulses left, including the one being emitted.
  - timer (TIMER_W): cycles elapsed in the current phase.
- IDLE:
  - `pulse_out`=0, `busy`=0.
  - `start`=1 and `num_pulses`≠0: latch remaining=`num_pulses`, clear timer, go to HIGH.
  - `start`=1 and `num_pulses`=0: stay in IDLE, assert `done` for one cycle, emit no pulses, never raise `busy`.
- HIGH:
  - `pulse_out`=1, `busy`=1.
  - Stay for HIGH_CYCLES cycles, then clear timer and go to LOW.
- LOW:
  - `pulse_out`=0, `busy`=1.
  - After LOW_CYCLES cycles: if remaining>1, decrement remaining, clear timer, go to HIGH.
  - If remaining=1: go to IDLE and assert `done` in the first IDLE cycle.
- The trailing LOW phase is mandatory, so back-to-back bursts always produce separable rising edges.
- `start` while `busy`=1 is ignored. `num_pulses` is not re-sampled.
- `cancel`=1 in HIGH or LOW:
  - Next cycle: IDLE, `pulse_out`=0, `busy`=0, `done`=0.
  - The truncated pulse is not completed.
- `cancel` and `start` in the same IDLE cycle: cancel wins, start is dropped.
- `cancel` in IDLE with no `start`: no effect.
- `done` is high for exactly one cycle per accepted start and is never asserted for a cancelled burst.
- remaining never wraps. The maximum burst is 2^CNT_W−1 pulses.

## Timing
- Reset values: `pulse_out`=0, `busy`=0, `done`=0; state=IDLE, remaining=0, timer=0.
- Reset applied mid-burst forces all outputs to 0 immediately, asynchronously. The first accepted start is the first one sampled after `reset` deasserts.
- Cycle numbering: `start` accepted at edge T; cycle T+k is the cycle after edge T+k.
- Pulse i (i=0..N−1) is high in cycles T+1+i·(H+L) through T+i·(H+L)+H.
- `busy` is high in cycles T+1 through T+N·(H+L).
- `done`=1 and `busy`=0 in cycle T+N·(H+L)+1.
- A `start` sampled during the `done` cycle is accepted (`busy`=0). Its first pulse begins the following cycle.
- Zero-count request: `done` in cycle T+1.
- Latency from `start` to the first `pulse_out` rising edge: 1 cycle.
- Latency from `cancel` to `pulse_out`=0 and `busy`=0: 1 cycle.

## Test plan
- H=2, L=3, start with `num_pulses`=3 at cycle 0 → `pulse_out` high in cycles 1–2, 6–7 and 11–12; `busy` high in cycles 1–15; `done` high only in cycle 16.
- `num_pulses`=0 start → `done` high in cycle 1 only; `busy` and `pulse_out` stay 0 throughout.
- Burst of 3 in progress; `start` with `num_pulses`=5 at cycle 4 → ignored, exactly 3 pulses, `done` at cycle 16.
- `cancel` at cycle 6 of a 3-pulse burst (inside pulse 2) → `pulse_out`=0 and `busy`=0 in cycle 7; `done` never asserts; a new start in cycle 8 produces a clean full burst.
- Assert `reset` asynchronously mid-HIGH → outputs drop to 0 without waiting for a clock edge; after release, a 1-pulse start gives high in cycles 1–2 and `done` at cycle 6.
- Back-to-back: second `start` (`num_pulses`=1) sampled in the `done` cycle 16 → pulse high in cycles 17–18, `done` at cycle 22; at least L=3 low cycles between bursts.
